ahb_bus_arbiter: RTL and testbench

Two-requester round-robin arbiter and transfer sequencer for the single-slave AHB memory, which answers one cycle after a NONSEQ address phase. Each requester presents a full read or write request on a hold-until-ack interface. The arbiter grants one requester at a time and drives a single-beat NONSEQ address/data phase to the slave. It then waits for the slave's HREADY pulse and returns read data, or a timeout error, to the granted requester. It is the only bus driver in front of the slave.

---
 rtl/ahb_bus_arbiter.sv | 82 ++++++++
 tb/tb_ahb_bus_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: two-requester round-robin arbiter issuing single-beat NONSEQ
// transfers to one AHB slave, with a WAIT-state timeout that returns an error.
module ahb_bus_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [31:0] HADDR,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY
);
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT} state_t;
  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT);
  state_t state, nxt;
  logic last, sel, grant, done, tout, elig0, elig1;
  logic [7:0] cnt;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) state <= S_IDLE;
    else state <= nxt;
  always_comb
    nxt = grant ? S_ADDR : state == S_ADDR ? S_WAIT : done ? S_IDLE : state;
  // A requester whose ack is high this cycle has not had a chance to drop req yet.
  always_comb begin
    elig0 = req0 && !ack0;
    elig1 = req1 && !ack1;
    sel   = (elig0 && elig1) ? !last : elig1;
    grant = state == S_IDLE && (elig0 || elig1);
    tout  = !HREADY;
    done  = state == S_WAIT && (HREADY || cnt == CNT_MAX);
  end
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      last   <= 1'b1;
      cnt    <= '0;
      HTRANS <= 2'b00;
      HWRITE <= 1'b0;
      HADDR  <= '0;
      HWDATA <= '0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      err0   <= 1'b0;
      err1   <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      ack0 <= done && !last;
      ack1 <= done && last;
      err0 <= done && !last && tout;
      err1 <= done && last && tout;
      if (grant) begin
        HTRANS <= 2'b10;
        HWRITE <= sel ? wr1 : wr0;
        HADDR  <= sel ? addr1 : addr0;
        HWDATA <= sel ? wdata1 : wdata0;
        last   <= sel;
      end
      if (state == S_ADDR) begin
        HTRANS <= 2'b00;
        cnt    <= '0;
      end
      if (state == S_WAIT && !done) cnt <= cnt + 8'd1;
      if (done && !last && (tout || !HWRITE)) rdata0 <= tout ? 32'h0 : HRDATA;
      if (done && last && (tout || !HWRITE)) rdata1 <= tout ? 32'h0 : HRDATA;
    end
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter: scoreboard bench with a behavioural one-wait-state slave.
module tb_ahb_bus_arbiter;
  logic HCLK = 0, HRESETn = 0;
  logic req0 = 0, req1 = 0, wr0 = 0, wr1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [1:0] HTRANS;
  logic HWRITE;
  logic [31:0] HADDR, HWDATA;
  logic [31:0] HRDATA = 0;
  logic HREADY = 0;
  logic slave_en = 1, pend = 0, prev_ns = 0;
  logic [31:0] mem [logic [31:0]];
  int errors = 0, checks = 0;
  typedef struct {int who; logic err; logic rd; logic [31:0] rdata;} exp_t;
  exp_t sb[$];

  ahb_bus_arbiter #(.TIMEOUT(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HADDR(HADDR), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY)
  );

  always #5 HCLK = ~HCLK;

  // Slave answers in the cycle after the NONSEQ address phase.
  always @(negedge HCLK) begin
    HREADY = pend && slave_en;
    HRDATA = 32'hBAD0_0000;
    if (HREADY) begin
      if (HWRITE) mem[HADDR] = HWDATA;
      else HRDATA = mem.exists(HADDR) ? mem[HADDR] : 32'h0;
    end
    pend = HTRANS == 2'b10;
  end

  always @(negedge HCLK) begin
    if (HTRANS == 2'b10) begin
      checks++;
      if (prev_ns) begin
        errors++;
        $display("FAIL back_to_back_nonseq: HTRANS=%b in two consecutive cycles, required 00 in between", HTRANS);
      end
    end
    prev_ns = HTRANS == 2'b10;
  end

  task automatic xfer(input int who, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic xerr, input logic [31:0] xrd,
                      output int ns_at, output int ack_at, output logic [31:0] rd_got);
    exp_t e;
    sb.push_back('{who, xerr, !w, xrd});
    if (who == 1) begin wr1 = w; addr1 = a; wdata1 = d; req1 = 1; end
    else begin wr0 = w; addr0 = a; wdata0 = d; req0 = 1; end
    ns_at = -1;
    ack_at = -1;
    rd_got = 'x;
    for (int k = 1; k <= 60 && ack_at < 0; k++) begin
      @(negedge HCLK);
      if (HTRANS == 2'b10 && ns_at < 0) begin
        ns_at = k;
        checks++;
        if ({HWRITE, HADDR, HWDATA} !== {w, a, d}) begin
          errors++;
          $display("FAIL nonseq_phase: got wr=%b addr=%h wdata=%h, required wr=%b addr=%h wdata=%h",
                   HWRITE, HADDR, HWDATA, w, a, d);
        end
      end
      if (ack0 || ack1) ack_at = k;
    end
    e = sb.pop_front();
    checks++;
    if (ack_at < 0) begin
      errors++;
      $display("FAIL ack_wait: no ack within 60 cycles for requester %0d, required one", e.who);
    end else begin
      rd_got = e.who == 1 ? rdata1 : rdata0;
      if (ack0 !== (e.who == 0) || ack1 !== (e.who == 1) || (e.who == 1 ? err1 : err0) !== e.err ||
          (e.rd && rd_got !== e.rdata)) begin
        errors++;
        $display("FAIL ack_result: got ack0=%b ack1=%b err=%b rdata=%h, required requester %0d err=%b rdata=%h",
                 ack0, ack1, e.who == 1 ? err1 : err0, rd_got, e.who, e.err, e.rdata);
      end
    end
    if (who == 1) req1 = 0;
    else req0 = 0;
  endtask

  task automatic test_reset();
    HRESETn = 0;
    repeat (2) @(negedge HCLK);
    checks++;
    if ({HTRANS, HWRITE, HADDR, HWDATA} !== 67'h0) begin
      errors++;
      $display("FAIL reset_bus: got HTRANS=%b HWRITE=%b HADDR=%h HWDATA=%h, required all 0", HTRANS, HWRITE, HADDR, HWDATA);
    end
    checks++;
    if ({ack0, ack1, err0, err1} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ack: got ack0/ack1/err0/err1=%b, required 0000", {ack0, ack1, err0, err1});
    end
    checks++;
    if ({rdata0, rdata1} !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata: got rdata0=%h rdata1=%h, required 0", rdata0, rdata1);
    end
    HRESETn = 1;
  endtask

  task automatic test_single_write();
    int ns, ak;
    logic [31:0] rd;
    xfer(0, 1, 32'h10, 32'hDEADBEEF, 0, 0, ns, ak, rd);
    checks++;
    if (ns !== 1 || ak !== 3) begin
      errors++;
      $display("FAIL write_latency: got NONSEQ at +%0d ack at +%0d, required +1 and +3", ns, ak);
    end
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL write_rdata_hold: got rdata0=%h, required 00000000", rd);
    end
  endtask

  task automatic test_write_read();
    int ns, ak;
    logic [31:0] rd;
    xfer(0, 1, 32'h24, 32'hCAFE0001, 0, 0, ns, ak, rd);
    xfer(1, 0, 32'h24, 32'h0, 0, 32'hCAFE0001, ns, ak, rd);
    checks++;
    if (ns !== 1 || ak !== 3) begin
      errors++;
      $display("FAIL read_latency: got NONSEQ at +%0d ack at +%0d, required +1 and +3", ns, ak);
    end
  endtask

  task automatic test_timeout();
    int ns, ak;
    logic [31:0] rd;
    slave_en = 0;
    xfer(1, 0, 32'h40, 32'h0, 1, 32'h0, ns, ak, rd);
    checks++;
    if (ak - ns !== 18) begin
      errors++;
      $display("FAIL timeout_latency: got ack %0d cycles after NONSEQ, required 18", ak - ns);
    end
    slave_en = 1;
    xfer(0, 0, 32'h24, 32'h0, 0, 32'hCAFE0001, ns, ak, rd);
    checks++;
    if (ns !== 1 || ak !== 3) begin
      errors++;
      $display("FAIL after_timeout: got NONSEQ at +%0d ack at +%0d, required +1 and +3", ns, ak);
    end
  endtask

  task automatic test_ack_mask();
    bit got = 0;
    int n = 0;
    wr0 = 0;
    addr0 = 32'h24;
    req0 = 1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge HCLK);
      got = ack0;
    end
    @(posedge HCLK);
    #1 req0 = 0;
    repeat (8) begin
      @(negedge HCLK);
      if (HTRANS == 2'b10) n++;
    end
    checks++;
    if (!got || n != 0) begin
      errors++;
      $display("FAIL ack_mask: got ack0_seen=%0d extra NONSEQ=%0d, required 1 and 0", got, n);
    end
  endtask

  task automatic test_contention();
    int n0 = 0, n1 = 0, gw;
    bit r0 = 0, r1 = 0;
    int gq[$] = '{0, 1, 0, 1, 0, 1};
    logic [31:0] exp_a;
    HRESETn = 0;
    wr0 = 1; wr1 = 1;
    addr0 = 32'h100; addr1 = 32'h200;
    wdata0 = 32'hA0; wdata1 = 32'hB0;
    req0 = 1; req1 = 1;
    repeat (2) @(negedge HCLK);
    HRESETn = 1;
    for (int k = 0; k < 80 && !(n0 == 3 && n1 == 3); k++) begin
      @(negedge HCLK);
      if (r0) begin req0 = 1; r0 = 0; end
      if (r1) begin req1 = 1; r1 = 0; end
      if (HTRANS == 2'b10) begin
        gw = gq.size() > 0 ? gq.pop_front() : -1;
        exp_a = gw == 1 ? 32'h200 + 32'(4 * n1) : 32'h100 + 32'(4 * n0);
        checks++;
        if (gw < 0 || HADDR !== exp_a) begin
          errors++;
          $display("FAIL contention_grant: got HADDR=%h, required requester %0d addr %h", HADDR, gw, exp_a);
        end
      end
      if (ack0) begin
        checks++;
        if (err0 !== 1'b0) begin errors++; $display("FAIL contention_err0: got %b, required 0", err0); end
        n0++;
        req0 = 0;
        addr0 = 32'h100 + 32'(4 * n0);
        wdata0 = 32'hA0 + 32'(n0);
        r0 = n0 < 3;
      end
      if (ack1) begin
        checks++;
        if (err1 !== 1'b0) begin errors++; $display("FAIL contention_err1: got %b, required 0", err1); end
        n1++;
        req1 = 0;
        addr1 = 32'h200 + 32'(4 * n1);
        wdata1 = 32'hB0 + 32'(n1);
        r1 = n1 < 3;
      end
    end
    checks++;
    if (n0 != 3 || n1 != 3 || gq.size() != 0) begin
      errors++;
      $display("FAIL contention_count: got %0d/%0d transfers, %0d grants missing, required 3/3 and 0", n0, n1, gq.size());
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0, any_ack = 0, first = 1;
    int n0 = 0, n1 = 0;
    wr0 = 0;
    addr0 = 32'h24;
    req0 = 1;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge HCLK);
      seen = HTRANS == 2'b10;
    end
    @(negedge HCLK);
    HRESETn = 0;
    #1;
    checks++;
    if (!seen || {HTRANS, HWRITE, HADDR, HWDATA} !== 67'h0) begin
      errors++;
      $display("FAIL midreset_bus: seen=%0d HTRANS=%b HWRITE=%b HADDR=%h HWDATA=%h, required seen=1 and all 0",
               seen, HTRANS, HWRITE, HADDR, HWDATA);
    end
    checks++;
    if ({ack0, ack1, err0, err1, rdata0, rdata1} !== 68'h0) begin
      errors++;
      $display("FAIL midreset_out: got ack/err=%b rdata0=%h rdata1=%h, required 0", {ack0, ack1, err0, err1}, rdata0, rdata1);
    end
    req0 = 0;
    repeat (3) begin
      @(negedge HCLK);
      any_ack |= ack0 | ack1;
    end
    checks++;
    if (any_ack) begin
      errors++;
      $display("FAIL midreset_noack: got ack during reset, required none");
    end
    HRESETn = 1;
    wr0 = 0; wr1 = 0;
    addr0 = 32'h300; addr1 = 32'h304;
    req0 = 1; req1 = 1;
    for (int k = 0; k < 30 && !(n0 == 1 && n1 == 1); k++) begin
      @(negedge HCLK);
      if (HTRANS == 2'b10 && first) begin
        first = 0;
        checks++;
        if (HADDR !== 32'h300) begin
          errors++;
          $display("FAIL midreset_tie: got first grant HADDR=%h, required 00000300 (requester 0)", HADDR);
        end
      end
      if (ack0) begin n0++; req0 = 0; end
      if (ack1) begin n1++; req1 = 0; end
    end
    checks++;
    if (n0 != 1 || n1 != 1) begin
      errors++;
      $display("FAIL midreset_resume: got acks %0d/%0d, required 1/1", n0, n1);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_write_read();
    test_timeout();
    test_ack_mask();
    test_contention();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
